// File: rtl/serial_to_parallel_demux_if.sv
// Bundle of the serial input beat and parallel output word handshakes for
// serial_to_parallel_demux. The demux sits on the slave side. The upstream
// serial source and downstream consumer together form the master side.
interface serial_to_parallel_demux_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
);
  logic             serial_valid;
  logic             serial_data;
  logic             serial_ready;
  logic             parallel_valid;
  logic [WIDTH-1:0] parallel_data;
  logic             parallel_ready;
  logic [CNT_W-1:0] bit_count;

  modport master (
    output serial_valid, serial_data, parallel_ready,
    input  serial_ready, parallel_valid, parallel_data, bit_count
  );

  modport slave (
    input  serial_valid, serial_data, parallel_ready,
    output serial_ready, parallel_valid, parallel_data, bit_count
  );
endinterface

// File: rtl/serial_to_parallel_demux.sv
// Receive end of a bit-serial link. Accepted serial bits are placed LSB first
// into a collect register. Each completed word is handed to a one-deep output
// register with a valid/ready handshake. The next word can be collected while
// the previous word waits. Only the completing bit is stalled while the output
// slot is still occupied.
module serial_to_parallel_demux #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input logic                      clk,
  input logic                      rst,
  serial_to_parallel_demux_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] bit_count_r;
  logic [WIDTH-1:0] collect_r;
  logic             parallel_valid_r;
  logic [WIDTH-1:0] parallel_data_r;

  logic             at_last_s;
  logic             stall_s;
  logic             serial_ready_s;
  logic             accept_s;
  logic             complete_s;
  logic             drain_s;
  logic [WIDTH-1:0] merged_s;

  // Handshake decode: stall only the completing bit while the output slot is occupied.
  always_comb begin
    at_last_s = (bit_count_r == LAST_IDX);
    if (parallel_valid_r && !bus.parallel_ready && at_last_s) begin
      stall_s = 1'b1;
    end else begin
      stall_s = 1'b0;
    end
    serial_ready_s = !stall_s;
    accept_s       = bus.serial_valid && serial_ready_s;
    complete_s     = accept_s && at_last_s;
    drain_s        = parallel_valid_r && bus.parallel_ready;
  end

  // Collect register with the current serial bit merged at its position.
  always_comb begin
    merged_s              = collect_r;
    merged_s[bit_count_r] = bus.serial_data;
  end

  // Bit counter and collect register: advance on accepted beats, restart on completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_count_r <= {CNT_W{1'b0}};
      collect_r   <= {WIDTH{1'b0}};
    end else if (complete_s) begin
      bit_count_r <= {CNT_W{1'b0}};
      collect_r   <= {WIDTH{1'b0}};
    end else if (accept_s) begin
      bit_count_r <= bit_count_r + CNT_W'(1);
      collect_r   <= merged_s;
    end else begin
      bit_count_r <= bit_count_r;
      collect_r   <= collect_r;
    end
  end

  // Output slot: load on completion (wins over a drain at the same edge), clear on drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parallel_valid_r <= 1'b0;
      parallel_data_r  <= {WIDTH{1'b0}};
    end else if (complete_s) begin
      parallel_valid_r <= 1'b1;
      parallel_data_r  <= merged_s;
    end else if (drain_s) begin
      parallel_valid_r <= 1'b0;
      parallel_data_r  <= parallel_data_r;
    end else begin
      parallel_valid_r <= parallel_valid_r;
      parallel_data_r  <= parallel_data_r;
    end
  end

  assign bus.serial_ready   = serial_ready_s;
  assign bus.parallel_valid = parallel_valid_r;
  assign bus.parallel_data  = parallel_data_r;
  assign bus.bit_count      = bit_count_r;

endmodule

// File: tb/tb_serial_to_parallel_demux.sv
// Self-checking bench for serial_to_parallel_demux (WIDTH=8). A behavioural
// model tracks the word under assembly as an integer bit position plus an
// arithmetically built word, and tracks the single output slot. Directed
// scenarios use constant expectations. A randomized run compares the design
// against the model every cycle and scoreboards the drained words.
module tb_serial_to_parallel_demux;
  localparam int W  = 8;
  localparam int CW = $clog2(W);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_to_parallel_demux_if #(.WIDTH(W)) bus ();

  serial_to_parallel_demux #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // behavioural model state
  int         m_cnt;
  logic [7:0] m_coll;
  logic [7:0] m_pd;
  bit         m_pv;
  bit         m_rdy;
  bit         m_done;
  bit         m_acc;
  // values observed from the DUT just before the edge
  bit         obs_rdy;
  bit         obs_pv;
  logic [7:0] obs_pd;

  task automatic model_reset();
    m_cnt  = 0;
    m_coll = 8'h00;
    m_pd   = 8'h00;
    m_pv   = 1'b0;
  endtask

  // Drive one beat, sample the DUT before the edge, advance the model on the edge.
  task automatic cycle(input bit sv, input bit sd, input bit pr);
    bus.serial_valid   = sv;
    bus.serial_data    = sd;
    bus.parallel_ready = pr;
    m_rdy = !(m_pv && !pr && (m_cnt == W - 1));
    #2;
    obs_rdy = bus.serial_ready;
    obs_pv  = bus.parallel_valid;
    obs_pd  = bus.parallel_data;
    @(posedge clk);
    m_done = 1'b0;
    m_acc  = sv && m_rdy;
    if (m_acc) begin
      m_coll = m_coll | (8'(sd) << m_cnt);
      if (m_cnt == W - 1) begin
        m_pd   = m_coll;
        m_coll = 8'h00;
        m_cnt  = 0;
        m_pv   = 1'b1;
        m_done = 1'b1;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    if (!m_done && m_pv && pr) m_pv = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.serial_valid = 1'b0; bus.serial_data = 1'b0; bus.parallel_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++; if (bus.bit_count !== CW'(0)) begin failures++; $display("FAIL reset_bit_count got=%0d exp=0", bus.bit_count); end
    checks++; if (bus.parallel_valid !== 1'b0) begin failures++; $display("FAIL reset_pvalid got=%b exp=0", bus.parallel_valid); end
    checks++; if (bus.parallel_data !== 8'h00) begin failures++; $display("FAIL reset_pdata got=%h exp=00", bus.parallel_data); end
    rst = 1'b0;
    #1;
    checks++; if (bus.serial_ready !== 1'b1) begin failures++; $display("FAIL reset_sready got=%b exp=1", bus.serial_ready); end
    @(posedge clk); #1;
    model_reset();
  endtask

  task automatic test_single_word();
    logic [7:0] word = 8'hA5;
    int pulses = 0;
    for (int i = 0; i < W + 3; i++) begin
      if (i < W) cycle(1'b1, word[i], 1'b1);
      else       cycle(1'b0, 1'b0, 1'b1);
      checks++; if (bus.bit_count !== CW'(m_cnt)) begin failures++; $display("FAIL single_bit_count cyc=%0d got=%0d exp=%0d", i, bus.bit_count, m_cnt); end
      checks++; if (bus.parallel_valid !== m_pv) begin failures++; $display("FAIL single_pvalid cyc=%0d got=%b exp=%b", i, bus.parallel_valid, m_pv); end
      if (bus.parallel_valid === 1'b1) begin
        pulses++;
        checks++; if (bus.parallel_data !== 8'hA5) begin failures++; $display("FAIL single_pdata got=%h exp=a5", bus.parallel_data); end
      end
    end
    checks++; if (pulses != 1) begin failures++; $display("FAIL single_pulses got=%0d exp=1", pulses); end
    checks++; if (bus.parallel_data !== 8'hA5) begin failures++; $display("FAIL single_retain got=%h exp=a5", bus.parallel_data); end
  endtask

  task automatic test_gapped();
    logic [7:0] word = 8'hA5;
    int pulses = 0;
    for (int i = 0; i < 2 * W + 2; i++) begin
      if (i < 2 * W && i[0] == 1'b0) cycle(1'b1, word[i/2], 1'b1);
      else                           cycle(1'b0, 1'($urandom), 1'b1);
      checks++; if (bus.bit_count !== CW'(m_cnt)) begin failures++; $display("FAIL gap_bit_count cyc=%0d got=%0d exp=%0d", i, bus.bit_count, m_cnt); end
      checks++; if (bus.parallel_valid !== m_pv) begin failures++; $display("FAIL gap_pvalid cyc=%0d got=%b exp=%b", i, bus.parallel_valid, m_pv); end
      if (bus.parallel_valid === 1'b1) pulses++;
    end
    checks++; if (pulses != 1) begin failures++; $display("FAIL gap_pulses got=%0d exp=1", pulses); end
    checks++; if (bus.parallel_data !== 8'hA5) begin failures++; $display("FAIL gap_pdata got=%h exp=a5", bus.parallel_data); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] stream = 16'hC33C;
    int pulses = 0;
    int t0 = 0;
    for (int i = 0; i < 2 * W + 2; i++) begin
      if (i < 2 * W) cycle(1'b1, stream[i], 1'b1);
      else           cycle(1'b0, 1'b0, 1'b1);
      checks++; if (obs_rdy !== 1'b1) begin failures++; $display("FAIL b2b_sready cyc=%0d got=%b exp=1", i, obs_rdy); end
      if (bus.parallel_valid === 1'b1) begin
        if (pulses == 0) begin
          t0 = i;
          checks++; if (bus.parallel_data !== 8'h3C) begin failures++; $display("FAIL b2b_first got=%h exp=3c", bus.parallel_data); end
        end else begin
          checks++; if (i - t0 != W) begin failures++; $display("FAIL b2b_spacing got=%0d exp=%0d", i - t0, W); end
          checks++; if (bus.parallel_data !== 8'hC3) begin failures++; $display("FAIL b2b_second got=%h exp=c3", bus.parallel_data); end
        end
        pulses++;
      end
    end
    checks++; if (pulses != 2) begin failures++; $display("FAIL b2b_pulses got=%0d exp=2", pulses); end
  endtask

  task automatic test_stall();
    logic [7:0] first  = 8'h0F;
    logic [7:0] second = 8'hF0;
    for (int i = 0; i < W; i++) cycle(1'b1, first[i], 1'b1);
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, second[m_cnt], 1'b0);
      checks++; if (obs_rdy !== m_rdy) begin failures++; $display("FAIL stall_sready cyc=%0d got=%b exp=%b", i, obs_rdy, m_rdy); end
      checks++; if (bus.parallel_data !== 8'h0F || bus.parallel_valid !== 1'b1) begin failures++; $display("FAIL stall_hold cyc=%0d got=%b/%h exp=1/0f", i, bus.parallel_valid, bus.parallel_data); end
      checks++; if (bus.bit_count !== CW'(m_cnt)) begin failures++; $display("FAIL stall_bit_count cyc=%0d got=%0d exp=%0d", i, bus.bit_count, m_cnt); end
    end
    checks++; if (bus.bit_count !== CW'(7) || obs_rdy !== 1'b0) begin failures++; $display("FAIL stall_at_last got=%0d/%b exp=7/0", bus.bit_count, obs_rdy); end
    cycle(1'b1, second[7], 1'b1);
    checks++; if (obs_rdy !== 1'b1) begin failures++; $display("FAIL stall_release_sready got=%b exp=1", obs_rdy); end
    checks++; if (bus.parallel_valid !== 1'b1 || bus.parallel_data !== 8'hF0) begin failures++; $display("FAIL stall_release got=%b/%h exp=1/f0", bus.parallel_valid, bus.parallel_data); end
    checks++; if (bus.bit_count !== CW'(0)) begin failures++; $display("FAIL stall_release_count got=%0d exp=0", bus.bit_count); end
    cycle(1'b0, 1'b0, 1'b1);
    checks++; if (bus.parallel_valid !== 1'b0 || bus.parallel_data !== 8'hF0) begin failures++; $display("FAIL stall_drain got=%b/%h exp=0/f0", bus.parallel_valid, bus.parallel_data); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] first  = 8'h55;
    logic [7:0] second = 8'hAA;
    for (int i = 0; i < W; i++) cycle(1'b1, first[i], 1'b0);
    for (int i = 0; i < W; i++) begin
      cycle(1'b1, second[i], (i == W - 1));
      checks++; if (bus.parallel_valid !== 1'b1) begin failures++; $display("FAIL simul_no_gap cyc=%0d got=%b exp=1", i, bus.parallel_valid); end
      if (i < W - 1) begin
        checks++; if (bus.parallel_data !== 8'h55) begin failures++; $display("FAIL simul_hold cyc=%0d got=%h exp=55", i, bus.parallel_data); end
      end
    end
    checks++; if (bus.parallel_data !== 8'hAA) begin failures++; $display("FAIL simul_new got=%h exp=aa", bus.parallel_data); end
    cycle(1'b0, 1'b0, 1'b1);
    checks++; if (bus.parallel_valid !== 1'b0) begin failures++; $display("FAIL simul_drain got=%b exp=0", bus.parallel_valid); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] held = 8'h77;
    logic [7:0] word = 8'h81;
    int pulses = 0;
    for (int i = 0; i < W; i++) cycle(1'b1, held[i], 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0);
    bus.serial_valid = 1'b0;
    rst = 1'b1;
    #2;
    checks++; if (bus.bit_count !== CW'(0)) begin failures++; $display("FAIL rstmid_bit_count got=%0d exp=0", bus.bit_count); end
    checks++; if (bus.parallel_valid !== 1'b0) begin failures++; $display("FAIL rstmid_pvalid got=%b exp=0", bus.parallel_valid); end
    checks++; if (bus.parallel_data !== 8'h00) begin failures++; $display("FAIL rstmid_pdata got=%h exp=00", bus.parallel_data); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < W + 2; i++) begin
      if (i < W) cycle(1'b1, word[i], 1'b1);
      else       cycle(1'b0, 1'b0, 1'b1);
      if (bus.parallel_valid === 1'b1) begin
        pulses++;
        checks++; if (bus.parallel_data !== 8'h81) begin failures++; $display("FAIL rstmid_word got=%h exp=81", bus.parallel_data); end
      end
    end
    checks++; if (pulses != 1) begin failures++; $display("FAIL rstmid_pulses got=%0d exp=1", pulses); end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] acc = 8'h00;
    int nb = 0;
    int drained = 0;
    int produced = 0;
    bit sv, sd, pr;
    for (int i = 0; i < 420; i++) begin
      sv = ($urandom_range(3) != 0);
      sd = 1'($urandom);
      pr = (i >= 400) ? 1'b1 : ($urandom_range(2) != 0);
      if (i >= 400) sv = 1'b0;
      cycle(sv, sd, pr);
      checks++; if (obs_rdy !== m_rdy) begin failures++; $display("FAIL rnd_sready cyc=%0d got=%b exp=%b", i, obs_rdy, m_rdy); end
      if (obs_pv && pr) begin
        drained++;
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL rnd_extra_word cyc=%0d got=%h exp=none", i, obs_pd); end
        else begin
          logic [7:0] e = exp_q.pop_front();
          if (obs_pd !== e) begin failures++; $display("FAIL rnd_word cyc=%0d got=%h exp=%h", i, obs_pd, e); end
        end
      end
      if (m_acc) begin
        acc = acc | (8'(sd) << nb);
        nb++;
        if (nb == W) begin exp_q.push_back(acc); acc = 8'h00; nb = 0; produced++; end
      end
      checks++; if (bus.bit_count !== CW'(m_cnt)) begin failures++; $display("FAIL rnd_bit_count cyc=%0d got=%0d exp=%0d", i, bus.bit_count, m_cnt); end
      checks++; if (bus.parallel_valid !== m_pv) begin failures++; $display("FAIL rnd_pvalid cyc=%0d got=%b exp=%b", i, bus.parallel_valid, m_pv); end
      checks++; if (bus.parallel_data !== m_pd) begin failures++; $display("FAIL rnd_pdata cyc=%0d got=%h exp=%h", i, bus.parallel_data, m_pd); end
    end
    checks++; if (drained != produced || produced < 10) begin failures++; $display("FAIL rnd_word_count got=%0d exp=%0d", drained, produced); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_single_word();
    test_gapped();
    test_back_to_back();
    test_stall();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
